writeback_unit: RTL and testbench

Write-side front end for the CPU register file: merges single-cycle ALU results and variable-latency load results onto the register file's single write port (write_en / write_register_num / write_register_in). Load results are buffered in a small FIFO behind a valid/ready handshake. The unit also keeps a per-register scoreboard of outstanding loads, which decode uses to stall dependent instructions.

---
 rtl/writeback_unit.sv | 149 ++++++++++++++
 tb/tb_writeback_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file write-port front end: merges ALU results with FIFO-buffered load
// results and keeps a per-register scoreboard of loads still in flight.
module writeback_unit #(
  parameter int DATA_WIDTH      = 16,
  parameter int LOAD_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [2:0]            alu_dest,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  load_valid,
  input  logic [2:0]            load_dest,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  reserve_en,
  input  logic [2:0]            reserve_dest,
  output logic [7:0]            busy_mask,
  output logic                  sb_overflow,
  output logic                  write_en,
  output logic [2:0]            write_register_num,
  output logic [DATA_WIDTH-1:0] write_register_in
);

  localparam int              PTR_W    = $clog2(LOAD_FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(LOAD_FIFO_DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [2:0]            fifo_dest [LOAD_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [LOAD_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_cnt;
  logic                  push, pop, fifo_empty;
  logic [2:0]            head_dest;
  logic [DATA_WIDTH-1:0] head_data;

  logic                  vld_p0;
  logic [2:0]            dest_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p1;
  logic [2:0]            dest_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  logic [1:0]            sb_cnt  [8];
  logic [1:0]            sb_next [8];
  logic [7:0]            inc_vec, dec_vec;
  logic                  ovf_p0, ovf_p1;

  // Ready is derived from registered occupancy only; a same-cycle pop never raises it.
  assign fifo_empty = (fifo_cnt == '0);
  assign load_ready = (fifo_cnt != FULL_CNT);
  assign push       = load_valid && load_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign head_dest  = fifo_dest[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= load_dest;
      fifo_data[wr_ptr] <= load_data;
    end
  end

  // Stage p0: fixed-priority select, ALU first, then FIFO head
  always_comb begin
    vld_p0  = 1'b0;
    dest_p0 = alu_dest;
    data_p0 = alu_data;
    if (alu_valid) begin
      vld_p0 = 1'b1;
    end else if (pop) begin
      vld_p0  = 1'b1;
      dest_p0 = head_dest;
      data_p0 = head_data;
    end
  end

  // Stage p1: registered write port; address/data hold when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      dest_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        dest_p1 <= dest_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign write_en           = vld_p1;
  assign write_register_num = dest_p1;
  assign write_register_in  = data_p1;

  // Scoreboard decrements when the pop is selected, not when it reaches the port.
  assign inc_vec = reserve_en ? (8'd1 << reserve_dest) : 8'd0;
  assign dec_vec = pop        ? (8'd1 << head_dest)    : 8'd0;

  always_comb begin
    ovf_p0     = 1'b0;
    sb_next[0] = 2'd0;
    for (int i = 1; i < 8; i++) begin
      sb_next[i] = sb_cnt[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        if (sb_cnt[i] == 2'd3) ovf_p0 = 1'b1;
        else                   sb_next[i] = sb_cnt[i] + 2'd1;
      end else if (dec_vec[i] && !inc_vec[i] && sb_cnt[i] != 2'd0) begin
        sb_next[i] = sb_cnt[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) sb_cnt[i] <= 2'd0;
      ovf_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) sb_cnt[i] <= sb_next[i];
      ovf_p1 <= ovf_p0;
    end
  end

  assign sb_overflow = ovf_p1;

  always_comb begin
    busy_mask = 8'h00;
    for (int i = 1; i < 8; i++) busy_mask[i] = (sb_cnt[i] != 2'd0);
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_writeback_unit;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          alu_valid, load_valid, reserve_en;
  logic [2:0]    alu_dest, load_dest, reserve_dest;
  logic [DW-1:0] alu_data, load_data;
  logic          load_ready, sb_overflow, write_en;
  logic [7:0]    busy_mask;
  logic [2:0]    write_register_num;
  logic [DW-1:0] write_register_in;

  int n_checks = 0;
  int n_pass   = 0;

  writeback_unit #(.DATA_WIDTH(DW), .LOAD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .load_valid(load_valid), .load_dest(load_dest), .load_data(load_data),
    .load_ready(load_ready),
    .reserve_en(reserve_en), .reserve_dest(reserve_dest),
    .busy_mask(busy_mask), .sb_overflow(sb_overflow),
    .write_en(write_en), .write_register_num(write_register_num),
    .write_register_in(write_register_in)
  );

  always #5 clk = ~clk;

  // Reference model: pending loads as a queue, outstanding loads as integer counts.
  typedef struct packed { logic [2:0] d; logic [DW-1:0] v; } ld_t;
  ld_t           mq[$];
  int            mcnt[8];
  logic          m_wen, m_ovf;
  logic [2:0]    m_num;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    mq.delete();
    for (int r = 0; r < 8; r++) mcnt[r] = 0;
    m_wen = 0; m_ovf = 0; m_num = 0; m_data = 0;
  endtask

  function automatic logic [7:0] m_busy();
    logic [7:0] b = 8'h00;
    for (int r = 1; r < 8; r++) b[r] = (mcnt[r] > 0);
    return b;
  endfunction

  task automatic model_edge();
    bit  rdy = (mq.size() < DEPTH);
    bit  dec[8];
    ld_t h;
    for (int r = 0; r < 8; r++) dec[r] = 0;
    m_wen = 0;
    m_ovf = 0;
    if (alu_valid) begin
      m_wen = 1; m_num = alu_dest; m_data = alu_data;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_wen = 1; m_num = h.d; m_data = h.v; dec[h.d] = 1;
    end
    for (int r = 1; r < 8; r++) begin
      bit inc = reserve_en && (reserve_dest == r);
      if (inc && !dec[r]) begin
        if (mcnt[r] == 3) m_ovf = 1;
        else mcnt[r]++;
      end else if (dec[r] && !inc && mcnt[r] > 0) begin
        mcnt[r]--;
      end
    end
    if (load_valid && rdy) mq.push_back('{d: load_dest, v: load_data});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    load_valid = 0; load_dest = 0; load_data = 0;
    reserve_en = 0; reserve_dest = 0;
  endtask

  task automatic load_wb(input logic [2:0] d, input logic [DW-1:0] v);
    load_valid = 1; load_dest = d; load_data = v;
    tick();
    load_valid = 0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (write_en !== 1'b0) $display("FAIL reset_wen got=%0b exp=0", write_en); else n_pass++;
    n_checks++; if (load_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", load_ready); else n_pass++;
    n_checks++; if (busy_mask !== 8'h00) $display("FAIL reset_busy got=%h exp=00", busy_mask); else n_pass++;
    n_checks++; if (sb_overflow !== 1'b0) $display("FAIL reset_ovf got=%0b exp=0", sb_overflow); else n_pass++;
    n_checks++; if (write_register_num !== 3'd0 || write_register_in !== 16'h0000)
      $display("FAIL reset_port got=%0d/%h exp=0/0000", write_register_num, write_register_in); else n_pass++;
    reset_n = 1;
    tick(); tick();
    n_checks++; if (write_en !== 1'b0 || load_ready !== 1'b1)
      $display("FAIL idle got wen=%0b rdy=%0b exp wen=0 rdy=1", write_en, load_ready); else n_pass++;
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_dest = 3; alu_data = 16'h1234;
    tick();
    alu_valid = 0;
    n_checks++; if (write_en !== 1'b1 || write_register_num !== 3'd3 || write_register_in !== 16'h1234)
      $display("FAIL alu_write got=%0b/%0d/%h exp=1/3/1234", write_en, write_register_num, write_register_in); else n_pass++;
    tick();
    n_checks++; if (write_en !== 1'b0) $display("FAIL alu_once got=%0b exp=0", write_en); else n_pass++;
    n_checks++; if (write_register_num !== 3'd3 || write_register_in !== 16'h1234)
      $display("FAIL alu_hold got=%0d/%h exp=3/1234", write_register_num, write_register_in); else n_pass++;
  endtask

  task automatic test_load();
    reserve_en = 1; reserve_dest = 5;
    tick();
    reserve_en = 0;
    n_checks++; if (busy_mask !== 8'h20) $display("FAIL load_reserve got=%h exp=20", busy_mask); else n_pass++;
    load_valid = 1; load_dest = 5; load_data = 16'hBEEF;
    n_checks++; if (load_ready !== 1'b1) $display("FAIL load_ready got=%0b exp=1", load_ready); else n_pass++;
    tick();
    load_valid = 0;
    n_checks++; if (write_en !== 1'b0 || busy_mask !== 8'h20)
      $display("FAIL load_n1 got wen=%0b busy=%h exp wen=0 busy=20", write_en, busy_mask); else n_pass++;
    tick();
    n_checks++; if (write_en !== 1'b1 || write_register_num !== 3'd5 || write_register_in !== 16'hBEEF)
      $display("FAIL load_write got=%0b/%0d/%h exp=1/5/beef", write_en, write_register_num, write_register_in); else n_pass++;
    n_checks++; if (busy_mask !== 8'h00) $display("FAIL load_busy_clear got=%h exp=00", busy_mask); else n_pass++;
    tick();
  endtask

  task automatic test_contention();
    bit exp_rdy[8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    int li = 0;
    for (int r = 5; r < 8; r++) begin
      reserve_en = 1; reserve_dest = 3'(r);
      tick();
    end
    reserve_en = 0;
    n_checks++; if (busy_mask !== 8'he0) $display("FAIL cont_busy got=%h exp=e0", busy_mask); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      logic [2:0]    en;
      logic [DW-1:0] ed;
      logic          ew;
      alu_valid  = (k < 4);
      alu_dest   = 3'(k + 1);
      alu_data   = 16'h0100 + 16'(k + 1);
      load_valid = (li < 3);
      load_dest  = 3'(5 + li);
      load_data  = 16'hA005 + 16'(li);
      n_checks++; if (load_ready !== exp_rdy[k])
        $display("FAIL cont_ready[%0d] got=%0b exp=%0b", k, load_ready, exp_rdy[k]); else n_pass++;
      if (load_valid && load_ready) li++;
      tick();
      ew = (k < 7);
      en = (k < 7) ? 3'(k + 1) : 3'd7;
      ed = (en < 5) ? 16'h0100 + 16'(en) : 16'hA000 + 16'(en);
      n_checks++; if (write_en !== ew || write_register_num !== en || write_register_in !== ed)
        $display("FAIL cont_write[%0d] got=%0b/%0d/%h exp=%0b/%0d/%h", k,
                 write_en, write_register_num, write_register_in, ew, en, ed); else n_pass++;
    end
    idle_inputs();
    n_checks++; if (busy_mask !== 8'h00) $display("FAIL cont_busy_end got=%h exp=00", busy_mask); else n_pass++;
  endtask

  task automatic test_scoreboard();
    reserve_en = 1; reserve_dest = 2;
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (busy_mask !== 8'h04 || sb_overflow !== 1'b0)
      $display("FAIL sb_three got busy=%h ovf=%0b exp busy=04 ovf=0", busy_mask, sb_overflow); else n_pass++;
    tick();
    reserve_en = 0;
    n_checks++; if (sb_overflow !== 1'b1) $display("FAIL sb_ovf_pulse got=%0b exp=1", sb_overflow); else n_pass++;
    tick();
    n_checks++; if (sb_overflow !== 1'b0) $display("FAIL sb_ovf_once got=%0b exp=0", sb_overflow); else n_pass++;
    load_wb(3'd2, 16'h2001);
    load_wb(3'd2, 16'h2002);
    n_checks++; if (write_en !== 1'b1 || write_register_in !== 16'h2002 || busy_mask[2] !== 1'b1)
      $display("FAIL sb_two_wb got wen=%0b data=%h busy2=%0b exp 1/2002/1", write_en, write_register_in, busy_mask[2]); else n_pass++;
    load_wb(3'd2, 16'h2003);
    n_checks++; if (busy_mask[2] !== 1'b0) $display("FAIL sb_three_wb got=%0b exp=0", busy_mask[2]); else n_pass++;
    reserve_en = 1; reserve_dest = 2;
    tick();
    reserve_en = 0;
    load_valid = 1; load_dest = 2; load_data = 16'h2004;
    tick();
    load_valid = 0;
    reserve_en = 1; reserve_dest = 2;
    tick();
    reserve_en = 0;
    n_checks++; if (write_en !== 1'b1 || write_register_num !== 3'd2 || busy_mask[2] !== 1'b1)
      $display("FAIL sb_same_cycle got wen=%0b num=%0d busy2=%0b exp 1/2/1", write_en, write_register_num, busy_mask[2]); else n_pass++;
    load_wb(3'd2, 16'h2005);
    n_checks++; if (busy_mask !== 8'h00) $display("FAIL sb_final got=%h exp=00", busy_mask); else n_pass++;
  endtask

  task automatic test_r0();
    bit seen_ovf = 0;
    reserve_en = 1; reserve_dest = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (sb_overflow) seen_ovf = 1;
    end
    reserve_en = 0;
    n_checks++; if (busy_mask !== 8'h00 || seen_ovf !== 1'b0)
      $display("FAIL r0_reserve got busy=%h ovf=%0b exp busy=00 ovf=0", busy_mask, seen_ovf); else n_pass++;
    alu_valid = 1; alu_dest = 0; alu_data = 16'h0000;
    tick();
    alu_valid = 0;
    n_checks++; if (write_en !== 1'b1 || write_register_num !== 3'd0 || write_register_in !== 16'h0000)
      $display("FAIL r0_write got=%0b/%0d/%h exp=1/0/0000", write_en, write_register_num, write_register_in); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midstream();
    bit wrote = 0;
    reserve_en = 1; reserve_dest = 6;
    tick();
    reserve_en = 0;
    alu_valid = 1; alu_dest = 1; alu_data = 16'h00A1;
    load_valid = 1; load_dest = 6; load_data = 16'h1111;
    tick();
    load_dest = 7; load_data = 16'h2222;
    tick();
    n_checks++; if (load_ready !== 1'b0) $display("FAIL mid_full got=%0b exp=0", load_ready); else n_pass++;
    reset_n = 0;
    #1;
    n_checks++; if (write_en !== 1'b0 || write_register_num !== 3'd0 || write_register_in !== 16'h0000)
      $display("FAIL mid_port got=%0b/%0d/%h exp=0/0/0000", write_en, write_register_num, write_register_in); else n_pass++;
    n_checks++; if (load_ready !== 1'b1 || busy_mask !== 8'h00)
      $display("FAIL mid_state got rdy=%0b busy=%h exp rdy=1 busy=00", load_ready, busy_mask); else n_pass++;
    idle_inputs();
    @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (write_en) wrote = 1;
    end
    n_checks++; if (wrote !== 1'b0) $display("FAIL mid_dropped got=%0b exp=0", wrote); else n_pass++;
  endtask

  task automatic test_random();
    bit hold = 0;
    int errs = 0;
    for (int k = 0; k < 400; k++) begin
      alu_valid = ($urandom_range(0, 99) < 35);
      alu_dest  = 3'($urandom_range(0, 7));
      alu_data  = 16'($urandom);
      if (!hold) begin
        load_valid = ($urandom_range(0, 99) < 50);
        load_dest  = 3'($urandom_range(0, 7));
        load_data  = 16'($urandom);
      end
      reserve_en   = ($urandom_range(0, 99) < 30);
      reserve_dest = 3'($urandom_range(0, 7));
      n_checks++; if (load_ready !== (mq.size() < DEPTH)) begin
        $display("FAIL rand_ready[%0d] got=%0b exp=%0b", k, load_ready, (mq.size() < DEPTH)); errs++;
      end else n_pass++;
      hold = load_valid && !load_ready;
      tick();
      n_checks++; if (write_en !== m_wen || write_register_num !== m_num || write_register_in !== m_data) begin
        $display("FAIL rand_write[%0d] got=%0b/%0d/%h exp=%0b/%0d/%h", k,
                 write_en, write_register_num, write_register_in, m_wen, m_num, m_data); errs++;
      end else n_pass++;
      n_checks++; if (busy_mask !== m_busy() || sb_overflow !== m_ovf) begin
        $display("FAIL rand_sb[%0d] got busy=%h ovf=%0b exp busy=%h ovf=%0b", k,
                 busy_mask, sb_overflow, m_busy(), m_ovf); errs++;
      end else n_pass++;
      if (errs > 20) break;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_contention();
    test_scoreboard();
    test_r0();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
